bram_search_ctrl: RTL

BRAM_SEARCH_CTRL -- requirements
Module: bram_search_ctrl

---
 rtl/bram_search_pkg.sv | 16 +
 rtl/bram_search_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bram_search_pkg.sv
// bram_search_pkg
// Shared definitions for the BRAM linear-search controller: the FSM state
// type and the default RAM word/address widths used as parameter defaults.
package bram_search_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bram_search_ctrl.sv
// bram_search_ctrl
// Linear search of an external synchronous RAM (1-cycle read latency) for a
// key, from address 0 up to last_addr. Each address costs two cycles: RD
// issues the read, CMP compares the returned word. When idle, a host port
// may write the RAM directly; host writes during a search are dropped and
// flagged on host_wr_err.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, key, last_addr      search request, value to find, last address
//   host_we/addr/din           host write request (idle only)
//   host_wr_err                one-cycle pulse: a host write was rejected
//   ram_cs/we/oe/address/din   RAM control and write data
//   ram_dout                   RAM read data
//   busy, done                 search in progress, one-cycle completion pulse
//   found, position            result: key matched, first matching address
//   match_count                (BRAM_SEARCH_COUNT_EN only) number of matches
//
// Configuration: define BRAM_SEARCH_COUNT_EN to scan all addresses up to
// last_addr regardless of matches and report the match count.
module bram_search_ctrl
  import bram_search_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    key,
  input  logic [ADDRESS_WIDTH-1:0] last_addr,
  input  logic                     host_we,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]    host_din,
  output logic                     host_wr_err,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic                     ram_oe,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
`ifdef BRAM_SEARCH_COUNT_EN
  output logic [ADDRESS_WIDTH:0]   match_count,
`endif
  output logic [ADDRESS_WIDTH-1:0] position
);

`ifdef BRAM_SEARCH_COUNT_EN
  localparam bit STOP_ON_MATCH = 1'b0;
`else
  localparam bit STOP_ON_MATCH = 1'b1;
`endif

  state_t                   state, state_next;
  logic [DATA_WIDTH-1:0]    key_q;
  logic [ADDRESS_WIDTH-1:0] last_q;
  logic [ADDRESS_WIDTH-1:0] counter;
  logic                     hit;
  logic                     at_last;
  logic                     finish;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign hit     = (ram_dout == key_q);
  // Stopping on counter == last_q (rather than on counter overflow) lets a
  // full-range search end at the top address without wrapping.
  assign at_last = (counter == last_q);
  assign finish  = at_last || (hit && STOP_ON_MATCH);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next  = state;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_oe      = 1'b0;
    ram_address = '0;
    ram_din     = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RD;
        end else if (host_we && rst_n) begin
          // Gated by rst_n so a held reset keeps the RAM strobes low even
          // while the host is asserting a write.
          ram_cs      = 1'b1;
          ram_we      = 1'b1;
          ram_address = host_addr;
          ram_din     = host_din;
        end
      end
      RD: begin
        ram_cs      = 1'b1;
        ram_oe      = 1'b1;
        ram_address = counter;
        state_next  = CMP;
      end
      CMP:     state_next = finish ? DONE : RD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      last_q      <= '0;
      counter     <= '0;
      found       <= 1'b0;
      position    <= '0;
      host_wr_err <= 1'b0;
`ifdef BRAM_SEARCH_COUNT_EN
      match_count <= '0;
`endif
    end else begin
      // A write is rejected when a search is running or is being accepted
      // on the same edge.
      host_wr_err <= host_we && (busy || start);
      unique case (state)
        IDLE: begin
          if (start) begin
            key_q    <= key;
            last_q   <= last_addr;
            counter  <= '0;
            found    <= 1'b0;
            position <= '0;
`ifdef BRAM_SEARCH_COUNT_EN
            match_count <= '0;
`endif
          end
        end
        CMP: begin
          // Only the first match sets the position; later matches are
          // counted when the full scan is enabled.
          if (hit && !found) begin
            found    <= 1'b1;
            position <= counter;
          end
`ifdef BRAM_SEARCH_COUNT_EN
          if (hit) match_count <= match_count + (ADDRESS_WIDTH+1)'(1);
`endif
          if (!finish) counter <= counter + ADDRESS_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
